// File: rtl/alu_operand_sequencer_if.sv
// alu_operand_sequencer_if: operand/select/result bundle between the sequencer and its driver
interface alu_operand_sequencer_if #(parameter int DW = 4, parameter int RW = 8);
  logic [DW-1:0] din;
  logic          load;
  logic          clear;
  logic [RW-1:0] alu_res;
  logic [DW-1:0] x_out;
  logic [DW-1:0] y_out;
  logic [1:0]    sel_out;
  logic [RW-1:0] res_out;
  logic          res_valid;
  logic [2:0]    phase;
  modport master (output din, load, clear, alu_res,
                  input  x_out, y_out, sel_out, res_out, res_valid, phase);
  modport slave  (input  din, load, clear, alu_res,
                  output x_out, y_out, sel_out, res_out, res_valid, phase);
endinterface

// File: rtl/alu_operand_sequencer.sv
// alu_operand_sequencer: serial X/Y/select loader feeding the logical unit and capturing its result
// Optional load debounce filter enabled by defining ALU_SEQ_LOAD_DEBOUNCE_EN.
module alu_operand_sequencer #(
  parameter int DW = 4,
  parameter int RW = 8,
  parameter int DEB_CYCLES = 16
) (
  input logic clk,
  input logic rst,
  alu_operand_sequencer_if.slave bus
);
  typedef enum logic [2:0] {S_X = 3'd0, S_Y = 3'd1, S_OP = 3'd2, S_CAP = 3'd3, S_RES = 3'd4} state_t;
  state_t state, state_n;
  logic [DW-1:0] x, x_n, y, y_n;
  logic [1:0] sel, sel_n;
  logic [RW-1:0] res, res_n;
  logic vld, vld_n;
  logic load_f, load_q, strobe;
  if (DEB_CYCLES < 1) begin : g_chk
    $error("DEB_CYCLES must be at least 1");
  end
`ifdef ALU_SEQ_LOAD_DEBOUNCE_EN
  localparam int CW = $clog2(DEB_CYCLES + 1);
  logic [1:0] sync;
  logic [CW-1:0] cnt;
  // load_f flips only after the synchronized level disagrees for DEB_CYCLES straight cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= 2'b11;
      cnt <= '0;
      load_f <= 1'b1;
    end else begin
      sync <= {sync[0], bus.load};
      if (sync[1] != load_f) begin
        cnt <= (cnt == CW'(DEB_CYCLES - 1)) ? '0 : cnt + CW'(1);
        if (cnt == CW'(DEB_CYCLES - 1)) load_f <= sync[1];
      end else begin
        cnt <= '0;
      end
    end
  end
`else
  always_ff @(posedge clk) load_f <= rst ? 1'b1 : bus.load;
`endif
  // history resets high so a button held through reset gives no strobe
  always_ff @(posedge clk) load_q <= rst ? 1'b1 : load_f;
  assign strobe = load_f & ~load_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_X;
      x <= '0;
      y <= '0;
      sel <= '0;
      res <= '0;
      vld <= 1'b0;
    end else begin
      state <= state_n;
      x <= x_n;
      y <= y_n;
      sel <= sel_n;
      res <= res_n;
      vld <= vld_n;
    end
  end
  always_comb begin
    state_n = state;
    x_n = x;
    y_n = y;
    sel_n = sel;
    res_n = res;
    vld_n = vld;
    if (bus.clear) begin
      state_n = S_X;
      x_n = '0;
      y_n = '0;
      sel_n = '0;
      res_n = '0;
      vld_n = 1'b0;
    end else begin
      case (state)
        S_X:   if (strobe) begin x_n = bus.din; state_n = S_Y; end
        S_Y:   if (strobe) begin y_n = bus.din; state_n = S_OP; end
        S_OP:  if (strobe) begin sel_n = bus.din[1:0]; state_n = S_CAP; end
        S_CAP: begin res_n = bus.alu_res; vld_n = 1'b1; state_n = S_RES; end
        S_RES: if (strobe) begin x_n = bus.din; vld_n = 1'b0; state_n = S_Y; end
        default: begin state_n = S_X; vld_n = 1'b0; end
      endcase
    end
  end
  assign bus.x_out = x;
  assign bus.y_out = y;
  assign bus.sel_out = sel;
  assign bus.res_out = res;
  assign bus.res_valid = vld;
  assign bus.phase = state;
endmodule

// File: tb/tb_alu_operand_sequencer.sv
// tb_alu_operand_sequencer: table-driven directed checks of the operand sequencer
module tb_alu_operand_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  alu_operand_sequencer_if #(.DW(4), .RW(8)) bus ();
  alu_operand_sequencer #(.DW(4), .RW(8), .DEB_CYCLES(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct {
    logic [3:0] din;
    logic       clr;
    logic [7:0] ar;
    logic [3:0] ex;
    logic [3:0] ey;
    logic [1:0] esel;
    logic [7:0] eres;
    logic       evld;
    logic [2:0] eph;
  } vec_t;
  vec_t vt[11];
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask
  task automatic chk_all(input string tag, input vec_t v);
    chk({tag, ".x"}, {4'h0, bus.x_out}, {4'h0, v.ex});
    chk({tag, ".y"}, {4'h0, bus.y_out}, {4'h0, v.ey});
    chk({tag, ".sel"}, {6'h0, bus.sel_out}, {6'h0, v.esel});
    chk({tag, ".res"}, bus.res_out, v.eres);
    chk({tag, ".vld"}, {7'h0, bus.res_valid}, {7'h0, v.evld});
    chk({tag, ".ph"}, {5'h0, bus.phase}, {5'h0, v.eph});
  endtask
  // one load press of three cycles, then two idle cycles so S_CAP can complete
  task automatic press(input logic [3:0] d, input logic c, input logic [7:0] ar);
    @(negedge clk);
    bus.din = d;
    bus.clear = c;
    bus.alu_res = ar;
    bus.load = 1'b1;
    repeat (3) @(negedge clk);
    bus.load = 1'b0;
    bus.clear = 1'b0;
    repeat (2) @(negedge clk);
  endtask
  initial begin
    vt[0]  = '{4'hA, 1'b0, 8'h02, 4'hA, 4'h0, 2'd0, 8'h00, 1'b0, 3'd1};
    vt[1]  = '{4'h6, 1'b0, 8'h02, 4'hA, 4'h6, 2'd0, 8'h00, 1'b0, 3'd2};
    vt[2]  = '{4'h0, 1'b0, 8'h02, 4'hA, 4'h6, 2'd0, 8'h02, 1'b1, 3'd4};
    vt[3]  = '{4'hF, 1'b0, 8'h5A, 4'hF, 4'h6, 2'd0, 8'h02, 1'b0, 3'd1};
    vt[4]  = '{4'h3, 1'b0, 8'h5A, 4'hF, 4'h3, 2'd0, 8'h02, 1'b0, 3'd2};
    vt[5]  = '{4'hE, 1'b0, 8'h5A, 4'hF, 4'h3, 2'd2, 8'h5A, 1'b1, 3'd4};
    vt[6]  = '{4'h5, 1'b1, 8'h5A, 4'h0, 4'h0, 2'd0, 8'h00, 1'b0, 3'd0};
    vt[7]  = '{4'h3, 1'b0, 8'hC3, 4'h3, 4'h0, 2'd0, 8'h00, 1'b0, 3'd1};
    vt[8]  = '{4'h5, 1'b0, 8'hC3, 4'h3, 4'h5, 2'd0, 8'h00, 1'b0, 3'd2};
    vt[9]  = '{4'h3, 1'b1, 8'hC3, 4'h0, 4'h0, 2'd0, 8'h00, 1'b0, 3'd0};
    vt[10] = '{4'h9, 1'b0, 8'hC3, 4'h9, 4'h0, 2'd0, 8'h00, 1'b0, 3'd1};
    bus.din = 4'h0;
    bus.clear = 1'b0;
    bus.alu_res = 8'h00;
    bus.load = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk_all("held_load_reset", '{4'h0, 1'b0, 8'h00, 4'h0, 4'h0, 2'd0, 8'h00, 1'b0, 3'd0});
    bus.load = 1'b0;
`ifdef ALU_SEQ_LOAD_DEBOUNCE_EN
    begin
      int lat;
      repeat (40) @(negedge clk);
      bus.din = 4'hC;
      bus.load = 1'b1;
      repeat (10) @(negedge clk);
      bus.load = 1'b0;
      repeat (40) @(negedge clk);
      chk("deb_short_ph", {5'h0, bus.phase}, 8'h00);
      bus.load = 1'b1;
      lat = 0;
      while (bus.x_out !== 4'hC && lat < 40) begin
        @(negedge clk);
        lat++;
      end
      chk("deb_latency_ok", {7'h0, (lat >= 17 && lat <= 20)}, 8'h01);
      repeat (5) @(negedge clk);
      bus.load = 1'b0;
      repeat (40) @(negedge clk);
      chk("deb_long_ph", {5'h0, bus.phase}, 8'h01);
      bus.clear = 1'b1;
      @(negedge clk);
      bus.clear = 1'b0;
    end
`else
    repeat (2) @(negedge clk);
    for (int i = 0; i < 11; i++) begin
      press(vt[i].din, vt[i].clr, vt[i].ar);
      chk_all($sformatf("vec%0d", i), vt[i]);
    end
    press(4'h0, 1'b1, 8'h00);
    @(negedge clk);
    bus.din = 4'h7;
    bus.load = 1'b1;
    repeat (50) @(negedge clk);
    chk("hold50_ph", {5'h0, bus.phase}, 8'h01);
    chk("hold50_x", {4'h0, bus.x_out}, 8'h07);
    bus.din = 4'h2;
    bus.load = 1'b0;
    repeat (5) @(negedge clk);
    chk("hold50_after_ph", {5'h0, bus.phase}, 8'h01);
    chk("hold50_after_y", {4'h0, bus.y_out}, 8'h00);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
